// File: rtl/sample_router_if.sv
// Sink-side handshake bundle for sample_router: one-hot valid, per-sink ready,
// and the shared sample and channel buses.
interface sample_router_if #(
   parameter int BPS       = 24,
   parameter int NUM_SINKS = 3,
   parameter int CH_W      = 1
);
   logic [NUM_SINKS-1:0] out_valid;
   logic [NUM_SINKS-1:0] in_ready;
   logic [BPS-1:0]       out_sample;
   logic [CH_W-1:0]      out_channel;

   modport master (output out_valid, output out_sample, output out_channel, input in_ready);
   modport slave  (input out_valid, input out_sample, input out_channel, output in_ready);
endinterface

// File: rtl/sample_router.sv
// Drains a standard-read FIFO and hands each sample to the selected sink, tagged with
// its channel index. Optional macro SAMPLE_ROUTER_UNDERRUN_CNT_EN builds the underrun counter.
module sample_router #(
   parameter int                   BPS         = 24,
   parameter int                   NUM_SINKS   = 3,
   parameter int                   MODE_W      = 2,
   parameter int                   CHANNELS    = 2,
   parameter int                   CH_W        = 1,
   parameter logic [NUM_SINKS-1:0] STREAM_MASK = NUM_SINKS'(1)
) (
   input  logic              in_clk,
   input  logic              in_reset,
   input  logic [MODE_W-1:0] in_mode,
   input  logic [BPS-1:0]    in_fifo_dout,
   input  logic              in_fifo_empty,
   input  logic              in_fifo_prog_empty,
   output logic              out_fifo_rd_en,
   sample_router_if.master   sink,
   output logic              out_underrun,
   output logic [15:0]       out_underrun_cnt
);
   typedef enum logic [2:0] {IDLE, PRIME, FETCH, LOAD, OFFER} state_t;

   state_t               state_reg;
   logic [MODE_W-1:0]    act_reg;
   logic [CH_W-1:0]      ch_reg;
   logic [BPS-1:0]       sample_reg;
   logic                 valid_reg;
   logic [CH_W-1:0]      ch_next;
   logic [NUM_SINKS-1:0] valid_vec;
   logic                 fetching;
   logic                 handshake;

   function automatic logic is_stream(input logic [MODE_W-1:0] idx);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_SINKS; i++) begin
         if (32'(idx) == i) r = STREAM_MASK[i];
      end
      return r;
   endfunction

   // Read strobe and underrun pulse must land in the FETCH cycle itself so the
   // FIFO data is valid during LOAD; reset suppresses both immediately.
   assign fetching       = (state_reg == FETCH) && !in_reset;
   assign out_fifo_rd_en = fetching && !in_fifo_empty;
   assign out_underrun   = fetching && in_fifo_empty && is_stream(act_reg);

   assign ch_next   = (ch_reg == CH_W'(CHANNELS - 1)) ? '0 : ch_reg + 1'b1;
   assign handshake = valid_reg && sink.in_ready[act_reg];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SINKS; gi++) begin : g_valid
         assign valid_vec[gi] = valid_reg && (32'(act_reg) == gi);
      end
   endgenerate

   assign sink.out_valid   = valid_vec;
   assign sink.out_sample  = sample_reg;
   assign sink.out_channel = ch_reg;

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_reg  <= IDLE;
         act_reg    <= '0;
         ch_reg     <= '0;
         sample_reg <= '0;
         valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               act_reg <= in_mode;
               if (32'(in_mode) < NUM_SINKS)
                  state_reg <= is_stream(in_mode) ? PRIME : FETCH;
            end
            PRIME: begin
               if (!in_fifo_prog_empty) state_reg <= FETCH;
            end
            FETCH: begin
               if (!in_fifo_empty) begin
                  state_reg <= LOAD;
               end else if (is_stream(act_reg)) begin
                  // streaming sink must not starve: offer a silent sample
                  sample_reg <= '0;
                  valid_reg  <= 1'b1;
                  state_reg  <= OFFER;
               end
            end
            LOAD: begin
               sample_reg <= in_fifo_dout;
               valid_reg  <= 1'b1;
               state_reg  <= OFFER;
            end
            OFFER: begin
               if (handshake) begin
                  valid_reg <= 1'b0;
                  ch_reg    <= ch_next;
                  // sink changes are honoured only at a frame boundary
                  state_reg <= (ch_next == '0 && in_mode != act_reg) ? IDLE : FETCH;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef SAMPLE_ROUTER_UNDERRUN_CNT_EN
   logic [15:0] cnt_reg;

   always_ff @(posedge in_clk) begin
      if (in_reset)
         cnt_reg <= '0;
      else if (out_underrun && cnt_reg != 16'hFFFF)
         cnt_reg <= cnt_reg + 16'd1;
   end

   assign out_underrun_cnt = cnt_reg;
`else
   assign out_underrun_cnt = 16'h0000;
`endif
endmodule

// File: doc/sample_router.md
# sample_router

Parametrised successor to the fixed three-way sample switch between the sample FIFO and the output sinks (I2S, sample-to-UART). It drains a standard-read (non-FWFT) FIFO of `BPS`-bit samples and delivers each sample to one of `NUM_SINKS` sinks over a valid/ready handshake, tagging it with its channel index within a frame of `CHANNELS` samples. Sinks are either streaming, which need FIFO priming and get zero-fill on underrun, or elastic, which simply wait for data. Mode changes take effect only on frame boundaries.

## Interface
Parameters:
- `BPS`, 24, sample width in bits.
- `NUM_SINKS`, 3, number of sinks (≥1).
- `MODE_W`, 2, width of `in_mode`; 2^MODE_W ≥ NUM_SINKS.
- `CHANNELS`, 2, samples per frame (1 = mono, 2 = L/R).
- `CH_W`, 1, channel index width; 2^CH_W ≥ CHANNELS.
- `STREAM_MASK`, 3'b001, bit i = 1 makes sink i streaming; 0 makes it elastic.

Ports:
- `in_clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `in_reset`  in  1  synchronous, active-high reset.
- `in_mode`  in  MODE_W  selected sink index; values ≥ NUM_SINKS mean idle.
- `in_fifo_dout`  in  BPS  FIFO read data, valid on the cycle after `out_fifo_rd_en`.
- `in_fifo_empty`  in  1  FIFO empty.
- `in_fifo_prog_empty`  in  1  FIFO below the priming watermark.
- `out_fifo_rd_en`  out  1  FIFO read strobe, one cycle per sample.
- `in_ready`  in  NUM_SINKS  per-sink ready.
- `out_valid`  out  NUM_SINKS  one-hot valid to the active sink.
- `out_sample`  out  BPS  sample bus, shared by all sinks.
- `out_channel`  out  CH_W  channel index of `out_sample`.
- `out_underrun`  out  1  one-cycle pulse for each zero-fill sample.
- `out_underrun_cnt`  out  16  saturating underrun count (see Configuration).

## Operation
- Registers:
  - `act` holds the latched sink index.
  - `ch` holds the channel index.
  - The sample register drives `out_sample`.
- State machine states: IDLE, PRIME, FETCH, LOAD, OFFER.
- IDLE:
  - Latches `act` = `in_mode`.
  - Stays in IDLE while `in_mode` ≥ NUM_SINKS.
  - Otherwise goes to PRIME if `STREAM_MASK[act]`, or to FETCH if not.
- PRIME: waits while `in_fifo_prog_empty`=1. When it is 0, goes to FETCH.
- FETCH with `in_fifo_empty`=0:
  - Asserts `out_fifo_rd_en` for this cycle only.
  - Goes to LOAD.
- FETCH with `in_fifo_empty`=1:
  - Elastic sink: stays in FETCH.
  - Streaming sink: loads 0 into the sample register, pulses `out_underrun`, increments the count, and goes to OFFER.
- LOAD: captures `in_fifo_dout`, then goes to OFFER.
- OFFER:
  - `out_valid[act]`=1 and every other bit is 0.
  - `out_sample` and `out_channel` are held stable until `in_ready[act]`=1.
- On the handshake:
  - `ch` ← (ch+1) mod CHANNELS.
  - If the new `ch`=0 and `in_mode`≠`act`, go to IDLE; otherwise go to FETCH.
- `in_ready` bits of non-active sinks are ignored.
- `out_fifo_rd_en` is never asserted while `in_fifo_empty`=1, so the FIFO never underflows.

## Timing
- Reset values:
  - State = IDLE.
  - `out_valid`, `out_fifo_rd_en`, `out_sample`, `out_channel`, `out_underrun`, `out_underrun_cnt` = 0.
  - `act` = 0, `ch` = 0.
- Reset asserted mid-operation discards the in-flight sample. The next cycle shows reset values, and the sample is not replayed.
- Latency:
  - `out_fifo_rd_en` in cycle t, data captured at t+1, `out_valid` at t+2.
  - Best case is one sample every 3 cycles, with `in_ready` held high.
- Handshake: if `in_ready` is already high when `out_valid` rises, the transfer completes in that cycle. `out_valid` drops on the next cycle.
- Underrun path: FETCH to OFFER takes one cycle. `out_underrun` is high during the FETCH cycle.
- Mode change mid-frame: takes effect after the frame's last channel is accepted. IDLE costs one cycle, and a streaming target then re-primes.
- Count saturates at 16'hFFFF and does not wrap.

## Configuration
- `SAMPLE_ROUTER_UNDERRUN_CNT_EN` defined: `out_underrun_cnt` is a 16-bit saturating counter, cleared only by reset.
- Not defined: no counter register is built and `out_underrun_cnt` is tied to 0. The `out_underrun` pulse and zero-fill behaviour are unchanged.

## Test plan
- Reset: hold `in_reset` 3 cycles during OFFER. Required next cycle: `out_valid`=0, `out_sample`=0, `out_underrun_cnt`=0, `ch`=0.
- Elastic sink: `in_mode`=2, FIFO holds 24'h000001..24'h000004, `in_ready[2]`=1. Required: `out_sample` = 1,2,3,4; `out_channel` = 0,1,0,1; `out_valid`=3'b100; `out_valid` 2 cycles after each `out_fifo_rd_en`; no `out_fifo_rd_en` while empty.
- Priming: `in_mode`=0, `in_fifo_prog_empty`=1 for 20 cycles. Required: no `out_fifo_rd_en`; first `out_fifo_rd_en` 1 cycle after `in_fifo_prog_empty` falls.
- Underrun: streaming sink 0, FIFO emptied after 1 sample. Required: next samples are 0; one `out_underrun` pulse each; `out_underrun_cnt` reaches 3 after 3 fills (0 without the macro).
- Mode switch: `in_mode` changes 0→2 after the channel-0 handshake. Required: channel-1 sample still goes to sink 0; then IDLE 1 cycle; then sink 2 is served with no priming wait.
- Backpressure: `in_ready[act]`=0 for 10 cycles in OFFER. Required: `out_sample`, `out_channel`, `out_valid` stable, and no FIFO read during the stall.
